regfile_scrub: RTL
==================

// Module: regfile_scrub
// PURPOSE
//   Parametrised CPU register file: NRD asynchronous read ports and one synchronous write port.
//   Optional write-to-read bypass and a hardwired-zero r0.
//   Adds a secure scrub engine: on request, it clears every register, one per cycle.
//   Reads are masked to zero while a scrub is in progress.
//   Sits between the decode and writeback stages of the core. The security controller drives the scrub request.
// PARAMETERS
//   DATA_W   32  register width in bits
//   NREGS    32  number of registers; power of 2, >=2; AW = $clog2(NREGS)
//   NRD      2   number of read ports, >=1
//   BYPASS   1   1: same-cycle write data forwarded to matching read ports
//   ZERO_R0  1   1: r0 reads 0 and ignores writes
// PORTS
//   clk_i         in   1          clock; all state updates on posedge
//   rst_ni        in   1          synchronous, active-low reset
//   we_i          in   1          write enable
//   waddr_i       in   AW         write address
//   wdata_i       in   DATA_W     write data
//   raddr_i       in   NRD*AW     read addresses; port k = [k*AW +: AW]
//   rdata_o       out  NRD*DATA_W read data; port k = [k*DATA_W +: DATA_W]
//   scrub_req_i   in   1          start scrub (sampled in IDLE only)
//   scrub_busy_o  out  1          high while in SCRUB state
//   scrub_done_o  out  1          one-cycle pulse when the scrub completes
//   wr_drop_o     out  1          one-cycle pulse: a write was discarded during scrub
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge)
//   - All registers cleared to 0; FSM goes to IDLE; scrub counter set to 0.
//   - scrub_busy_o, scrub_done_o and wr_drop_o are registered and reset to 0.
//   - rdata_o is forced to 0 combinationally while rst_ni=0.
// - Write
//   - If we_i=1 in IDLE or DONE, reg[waddr_i] <= wdata_i at the posedge.
//   - With ZERO_R0=1, waddr_i==0 is ignored.
// - Read (combinational, 0-cycle latency)
//   - rdata_o[k] = reg[raddr_k].
//   - With ZERO_R0=1, raddr_k==0 returns 0.
// - Bypass
//   - With BYPASS=1, if we_i=1 && waddr_i==raddr_k && the write is accepted this cycle, rdata_o[k] = wdata_i.
//   - No bypass for r0 when ZERO_R0=1, and none during SCRUB.
// - FSM states: IDLE, SCRUB, DONE
//   - IDLE -> SCRUB when scrub_req_i=1. A write in that same cycle still commits.
//   - SCRUB:
//     - Each cycle reg[cnt] <= 0 and cnt <= cnt+1.
//     - When cnt==NREGS-1, go to DONE; cnt wraps to 0.
//     - The scrub lasts exactly NREGS cycles.
//     - scrub_busy_o=1 throughout SCRUB.
//     - All rdata_o ports return 0.
//     - we_i=1 is discarded, and wr_drop_o pulses the next cycle.
//     - scrub_req_i is ignored.
//   - DONE:
//     - Lasts one cycle; scrub_done_o=1 during it, then the FSM returns to IDLE.
//     - Writes and reads behave as in IDLE.
//     - scrub_req_i in DONE is ignored; a requester must re-assert in IDLE.
// - Reset mid-scrub: abort immediately and return to IDLE with all registers 0. scrub_done_o is not pulsed.
// - Port collision: multiple read ports may address the same register. Every read port is independent.
// TESTING
// - T1 write/read: write r5=0xDEADBEEF, then read r5 on ports 0 and 1 -> both return 0xDEADBEEF the next cycle.
// - T2 r0 and bypass:
//   - Write r0=0x1234 -> reads of r0 return 0.
//   - With we_i=1, waddr=7, wdata=0xA5A5A5A5 and raddr0=7 in the same cycle -> rdata0=0xA5A5A5A5 before the edge.
// - T3 scrub timing (NREGS=32):
//   - Fill r1..r31 with nonzero data, then pulse scrub_req_i.
//   - Required: scrub_busy_o high for 32 cycles, then scrub_done_o high for 1 cycle.
//   - Required: every register reads 0 afterwards.
// - T4 write during scrub: we_i=1, waddr=3, wdata=0xFF on scrub cycle 10.
//   - Required: wr_drop_o pulses once, and r3 reads 0 after DONE.
// - T5 reset mid-scrub: assert rst_ni=0 at scrub cycle 5.
//   - Required: scrub_busy_o=0 the next cycle and no scrub_done_o pulse.
//   - Required: a new scrub_req_i is accepted normally.
// - T6 simultaneous events: in IDLE, we_i=1 (r9=0x55) together with scrub_req_i.
//   - Required: the write commits, then the scrub clears r9, so r9 reads 0 after DONE.
//   - Also exercise a scrub_req_i held high through DONE -> exactly one scrub, then a new one starts from IDLE.

Source files
------------

// File: rtl/regfile_scrub.sv
// Register file with NRD asynchronous read ports, one synchronous write port,
// optional write-to-read bypass, optional hardwired-zero r0 and a scrub engine
// that clears every register, one per cycle, on request.
module regfile_scrub #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NRD     = 2,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [NRD*AW-1:0]     raddr_i,
    output logic [NRD*DATA_W-1:0] rdata_o,
    input  logic                  scrub_req_i,
    output logic                  scrub_busy_o,
    output logic                  scrub_done_o,
    output logic                  wr_drop_o
);

    typedef enum logic [1:0] {StIdle, StScrub, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              in_scrub;
    logic              wr_accept;

    assign in_scrub  = (state_q == StScrub);
    // r0 writes are swallowed here so the bypass path never forwards to r0 either.
    assign wr_accept = we_i && !in_scrub && !(ZERO_R0 && (waddr_i == '0));

    // Next-state: register contents, scrub pointer, FSM and registered flags.
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (wr_accept) begin
            regs_d[waddr_i] = wdata_i;
        end
        unique case (state_q)
            StIdle: begin
                if (scrub_req_i) begin
                    state_d = StScrub;
                    cnt_d   = '0;
                end
            end
            StScrub: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;  // wraps to 0 after the last register
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StScrub);
        done_d = (state_d == StDone);
        drop_d = in_scrub && we_i;
    end

    // State update with synchronous active-low reset; reset aborts any scrub.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: masked during reset and scrub, r0 hardwired, optional bypass.
    always_comb begin
        rdata_o = '0;
        if (rst_ni && !in_scrub) begin
            for (int k = 0; k < int'(NRD); k++) begin
                if (ZERO_R0 && (raddr_i[k*AW +: AW] == '0)) begin
                    rdata_o[k*DATA_W +: DATA_W] = '0;
                end else if (BYPASS && wr_accept && (waddr_i == raddr_i[k*AW +: AW])) begin
                    rdata_o[k*DATA_W +: DATA_W] = wdata_i;
                end else begin
                    rdata_o[k*DATA_W +: DATA_W] = regs_q[raddr_i[k*AW +: AW]];
                end
            end
        end
    end

    assign scrub_busy_o = busy_q;
    assign scrub_done_o = done_q;
    assign wr_drop_o    = drop_q;

endmodule
